// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one RSA decryption core between NUM_REQ requesters.
// Optional busy watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int WIDTH          = 256,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_d,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_n,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [WIDTH-1:0]         o_rsp_data,
   output logic [1:0]               o_rsp_id,
   output logic                     o_rsp_err,
   output logic                     o_core_start,
   output logic                     o_core_rst,
   output logic [WIDTH-1:0]         o_core_a,
   output logic [WIDTH-1:0]         o_core_d,
   output logic [WIDTH-1:0]         o_core_n,
   input  logic [WIDTH-1:0]         i_core_result,
   input  logic                     i_core_finished
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUSY, S_CLR, S_RSP} state_t;

   state_t             state;
   state_t             state_next;
   logic [1:0]         last_grant;
   logic [1:0]         grant;
   logic [1:0]         job_id;
   logic               grant_found;
   logic               accept;
   logic               timeout_hit;
   logic [NUM_REQ-1:0] rot;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_d;
   logic [WIDTH-1:0]   sel_n;
   int                 idx;

   // Marker scope that only elaborates for an out-of-range configuration.
   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_config
   end

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant       = last_grant;
      idx         = 0;
      rot         = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_grant) + i) % NUM_REQ;
         rot = i_req_valid >> idx;
         if (!grant_found && rot[0]) begin
            grant_found = 1'b1;
            grant       = 2'(idx);
         end
      end
   end

   assign accept      = grant_found && (state == S_IDLE);
   assign o_req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
   assign sel_a       = WIDTH'(i_req_a >> (int'(grant) * WIDTH));
   assign sel_d       = WIDTH'(i_req_d >> (int'(grant) * WIDTH));
   assign sel_n       = WIDTH'(i_req_n >> (int'(grant) * WIDTH));

`ifdef RSA_ARB_TIMEOUT_EN
   logic [31:0] busy_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_cnt <= '0;
      end else if (state == S_LOAD) begin
         busy_cnt <= '0;
      end else if (state == S_BUSY) begin
         busy_cnt <= busy_cnt + 32'd1;
      end
   end

   assign timeout_hit = (state == S_BUSY) && !i_core_finished &&
                        (busy_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_LOAD;
         S_LOAD:  state_next = S_BUSY;
         S_BUSY:  if (i_core_finished || timeout_hit) state_next = S_CLR;
         S_CLR:   state_next = S_RSP;
         S_RSP:   if (i_rsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Pulses and valid are derived from the next state so they line up with the state they belong to.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         last_grant   <= 2'(NUM_REQ - 1);
         job_id       <= '0;
         o_core_a     <= '0;
         o_core_d     <= '0;
         o_core_n     <= '0;
         o_core_start <= 1'b0;
         o_core_rst   <= 1'b0;
         o_rsp_valid  <= 1'b0;
         o_rsp_data   <= '0;
         o_rsp_id     <= '0;
         o_rsp_err    <= 1'b0;
      end else begin
         state        <= state_next;
         o_core_start <= (state_next == S_LOAD);
         o_core_rst   <= (state_next == S_CLR);
         o_rsp_valid  <= (state_next == S_RSP);
         if (accept) begin
            o_core_a   <= sel_a;
            o_core_d   <= sel_d;
            o_core_n   <= sel_n;
            job_id     <= grant;
            last_grant <= grant;
         end
         if (state == S_BUSY) begin
            if (i_core_finished) begin
               o_rsp_data <= i_core_result;
               o_rsp_id   <= job_id;
               o_rsp_err  <= 1'b0;
            end else if (timeout_hit) begin
               o_rsp_data <= '0;
               o_rsp_id   <= job_id;
               o_rsp_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Scoreboard bench for rsa_job_arbiter with a sticky-finish core model.
// Define RSA_ARB_TIMEOUT_EN to also exercise the busy watchdog.
module tb_rsa_job_arbiter;

   localparam int NUM_REQ = 2;
   localparam int WIDTH   = 256;
   localparam int TMO     = 50;

   logic                     i_clk = 1'b0;
   logic                     i_rst;
   logic [NUM_REQ-1:0]       i_req_valid;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic [NUM_REQ*WIDTH-1:0] i_req_a, i_req_d, i_req_n;
   logic                     o_rsp_valid;
   logic                     i_rsp_ready;
   logic [WIDTH-1:0]         o_rsp_data;
   logic [1:0]               o_rsp_id;
   logic                     o_rsp_err;
   logic                     o_core_start, o_core_rst;
   logic [WIDTH-1:0]         o_core_a, o_core_d, o_core_n;
   logic [WIDTH-1:0]         core_result;
   logic                     core_finished;

   typedef struct { logic [WIDTH-1:0] data; logic [1:0] id; logic err; } rsp_t;
   typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] d; logic [WIDTH-1:0] n; } ops_t;

   rsp_t rsp_q[$];
   ops_t ops_q[$];
   rsp_t rs;
   ops_t op;

   int  n_cmp = 0;
   int  n_fail = 0;
   int  cycle = 0;
   int  start_cnt = 0;
   int  crst_cnt = 0;
   int  last_start = 0;
   int  last_valid_rise = 0;
   bit  prev_valid = 1'b0;
   int  core_lat = 100;
   bit  core_never = 1'b0;
   int  core_cnt;
   bit  core_run;

   rsa_job_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_a(i_req_a), .i_req_d(i_req_d), .i_req_n(i_req_n),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err),
      .o_core_start(o_core_start), .o_core_rst(o_core_rst),
      .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
      .i_core_result(core_result), .i_core_finished(core_finished)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] a, d, n);
      longint unsigned b, e, m, r;
      m = n[63:0];
      if (m == 0) return '0;
      b = a[63:0] % m;
      e = d[63:0];
      r = 1 % m;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return WIDTH'(r);
   endfunction

   // Core model: fixed latency, finished stays high until the core is cleared.
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst || o_core_rst) begin
         core_finished <= 1'b0;
         core_result   <= '0;
         core_run      <= 1'b0;
         core_cnt      <= 0;
      end else if (o_core_start) begin
         core_run <= 1'b1;
         core_cnt <= core_lat;
      end else if (core_run && !core_never) begin
         if (core_cnt == 1) begin
            core_run      <= 1'b0;
            core_finished <= 1'b1;
            core_result   <= modexp(o_core_a, o_core_d, o_core_n);
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int k, input logic [WIDTH-1:0] a, d, n,
                                input logic [WIDTH-1:0] exp_data, input bit expect_rsp);
      i_req_a[k*WIDTH +: WIDTH] = a;
      i_req_d[k*WIDTH +: WIDTH] = d;
      i_req_n[k*WIDTH +: WIDTH] = n;
      i_req_valid[k] = 1'b1;
      ops_q.push_back('{a, d, n});
      if (expect_rsp) rsp_q.push_back('{exp_data, 2'(k), 1'b0});
   endtask

   // Returns #1 after the accepting edge with the requester's valid dropped.
   task automatic waitAccept(input int k, input string name);
      int t = 0;
      #1;
      while (!(i_req_valid[k] && o_req_ready[k]) && t < 1000) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 1000) checkOutput(name, '0, 1);
      @(posedge i_clk);
      #1;
      i_req_valid[k] = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int t = 0;
      @(negedge i_clk);
      while ((rsp_q.size() != 0 || o_rsp_valid) && t < 2000) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 2000) checkOutput(name, WIDTH'(rsp_q.size()), '0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a start or a response handshake.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         cycle++;
         if (o_core_start) begin
            start_cnt++;
            last_start = cycle;
            if (ops_q.size() == 0) begin
               checkOutput("unexpected_start", 1, 0);
            end else begin
               op = ops_q.pop_front();
               checkOutput("core_a", o_core_a, op.a);
               checkOutput("core_d", o_core_d, op.d);
               checkOutput("core_n", o_core_n, op.n);
            end
         end
         if (o_core_rst) crst_cnt++;
         if (o_rsp_valid && !prev_valid) last_valid_rise = cycle;
         prev_valid = o_rsp_valid;
         if (o_rsp_valid && i_rsp_ready) begin
            if (rsp_q.size() == 0) begin
               checkOutput("unexpected_rsp", 1, 0);
            end else begin
               rs = rsp_q.pop_front();
               checkOutput("rsp_data", o_rsp_data, rs.data);
               checkOutput("rsp_id", WIDTH'(o_rsp_id), WIDTH'(rs.id));
               checkOutput("rsp_err", WIDTH'(o_rsp_err), WIDTH'(rs.err));
            end
         end
      end else begin
         prev_valid = 1'b0;
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0, r0, bad, rbad, k;
      i_rst = 1'b1;
      i_req_valid = '0;
      i_req_a = '0;
      i_req_d = '0;
      i_req_n = '0;
      i_rsp_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rst_core_ops", o_core_a | o_core_d | o_core_n, '0);
      checkOutput("rst_flags", WIDTH'({o_core_start, o_core_rst, o_rsp_valid, o_rsp_err, o_rsp_id}), '0);
      checkOutput("rst_data", o_rsp_data, '0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      checkOutput("idle_ready", WIDTH'(o_req_ready), '0);

      $display("[TB] single job");
      s0 = start_cnt;
      r0 = crst_cnt;
      core_lat = 100;
      @(posedge i_clk);
      #1 applyStimulus(0, 3, 5, 7, 5, 1'b1);
      waitAccept(0, "single_accept");
      checkOutput("start_after_accept", WIDTH'(o_core_start), 1);
      waitDrain("single_drain");
      checkOutput("single_start_pulses", WIDTH'(start_cnt - s0), 1);
      checkOutput("single_rst_pulses", WIDTH'(crst_cnt - r0), 1);
      checkOutput("single_latency", WIDTH'(last_valid_rise - last_start), 103);

      $display("[TB] contention");
      core_lat = 10;
      @(posedge i_clk);
      #1 i_rst = 1'b1;
      applyStimulus(0, 2, 10, 1000, 24, 1'b1);
      applyStimulus(1, 5, 3, 13, 8, 1'b1);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         int t = 0;
         #1;
         while (!(|(i_req_valid & o_req_ready)) && t < 1000) begin
            @(negedge i_clk);
            t++;
         end
         k = o_req_ready[1] ? 1 : 0;
         checkOutput("accept_order", WIDTH'(k), WIDTH'(j % 2));
         @(posedge i_clk);
         #1;
         if (j == 0) applyStimulus(0, 4, 3, 11, 9, 1'b1);
         else if (j == 1) applyStimulus(1, 7, 2, 10, 9, 1'b1);
         else i_req_valid[k] = 1'b0;
      end
      waitDrain("contention_drain");

      $display("[TB] back-pressure");
      @(posedge i_clk);
      #1 i_rsp_ready = 1'b0;
      applyStimulus(1, 3, 4, 5, 1, 1'b1);
      waitAccept(1, "bp_accept");
      applyStimulus(0, 6, 3, 7, 6, 1'b1);
      for (int t = 0; t < 1000 && !o_rsp_valid; t++) @(negedge i_clk);
      bad = 0;
      rbad = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge i_clk);
         if (!o_rsp_valid || o_rsp_data !== WIDTH'(1) || o_rsp_id !== 2'd1) bad++;
         if (o_req_ready !== '0) rbad++;
      end
      checkOutput("bp_hold", WIDTH'(bad), '0);
      checkOutput("bp_ready_low", WIDTH'(rbad), '0);
      @(posedge i_clk);
      #1 i_rsp_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("bp_resume", WIDTH'(o_req_ready), WIDTH'(2'b01));
      waitAccept(0, "bp_accept2");
      waitDrain("bp_drain");

      $display("[TB] sticky finish");
      core_lat = 20;
      applyStimulus(0, 2, 5, 13, 6, 1'b1);
      waitAccept(0, "sticky_accept1");
      waitDrain("sticky_drain1");
      applyStimulus(0, 3, 3, 17, 10, 1'b1);
      waitAccept(0, "sticky_accept2");
      waitDrain("sticky_drain2");
      checkOutput("sticky_latency", WIDTH'(last_valid_rise - last_start), 23);

      $display("[TB] reset mid-job");
      applyStimulus(0, 9, 9, 11, 0, 1'b0);
      waitAccept(0, "midrst_accept");
      repeat (10) @(posedge i_clk);
      #1 i_rst = 1'b1;
      i_req_valid = '0;
      @(negedge i_clk);
      checkOutput("midrst_core_ops", o_core_a | o_core_d | o_core_n, '0);
      checkOutput("midrst_flags", WIDTH'({o_core_start, o_core_rst, o_rsp_valid, o_rsp_err, o_rsp_id}), '0);
      checkOutput("midrst_data", o_rsp_data, '0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      applyStimulus(0, 5, 2, 9, 7, 1'b1);
      applyStimulus(1, 2, 7, 100, 28, 1'b1);
      @(negedge i_clk);
      checkOutput("midrst_first_grant", WIDTH'(o_req_ready), WIDTH'(2'b01));
      waitAccept(0, "midrst_accept0");
      waitAccept(1, "midrst_accept1");
      waitDrain("midrst_drain");

`ifdef RSA_ARB_TIMEOUT_EN
      $display("[TB] timeout");
      core_never = 1'b1;
      r0 = crst_cnt;
      applyStimulus(0, 3, 5, 7, 0, 1'b0);
      rsp_q.push_back('{'0, 2'd0, 1'b1});
      waitAccept(0, "timeout_accept");
      waitDrain("timeout_drain");
      checkOutput("timeout_rst_pulse", WIDTH'(crst_cnt - r0), 1);
      checkOutput("timeout_latency", WIDTH'(last_valid_rise - last_start), TMO + 2);
      core_never = 1'b0;
`endif

      repeat (3) @(negedge i_clk);
      checkOutput("sb_rsp_drained", WIDTH'(rsp_q.size()), '0);
      checkOutput("sb_ops_drained", WIDTH'(ops_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
